systolic_feeder: RTL and testbench

- Transmit side of the PE-array edge interface. Takes one A-column slice and one B-row slice per beat over valid/ready.
- Drives the array's left edge (left_in of row r) and top edge (top_in of column c). Lane i is skewed by i cycles.
- Sequences the array control: a clear (array reset) before the job, flush after the last beat, then an N-cycle drain (through) so accumulators shift out the bottom edge.
- Sits between the operand buffers and the N×N PE grid.

---
 rtl/tpu_pkg.sv | 17 +
 rtl/systolic_feeder_skew_line.sv | 34 +++
 rtl/systolic_feeder.sv | 137 +++++++++++++
 tb/tb_systolic_feeder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and default sizes for the PE-array edge logic.
package tpu_pkg;

  localparam int N_DEF  = 4;
  localparam int W_DEF  = 8;
  localparam int KW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth register delay used to skew one operand lane; DEPTH=0 is a wire.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, reset, clear};
      assign dout      = din;
    end else begin : g_regs
      logic [W-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
          stage[0] <= din;
          for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the PE-array edge: skews A/B lanes onto the array and sequences clear/flush/drain.
// Optional FEEDER_STALL_CNT_EN adds stall_cnt, a saturating count of FEED cycles without in_valid.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle array reset before the job
// FEED  | accepting operand beats, pushing them into the skew lines
// FLUSH | pushing zeros for 2N-1 cycles until the last beat reaches PE(N-1,N-1)
// DRAIN | arr_through for N cycles, accumulators shift out the bottom edge
// DONE  | one-cycle done pulse
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int KW = KW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [KW-1:0]  k_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a_vec,
  input  logic [N*W-1:0] b_vec,
  output logic [N*W-1:0] left_out,
  output logic [N*W-1:0] top_out,
  output logic           arr_reset,
  output logic           arr_through,
  output logic           busy,
  output logic           done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  localparam int            TW        = $clog2(2 * N);
  localparam logic [TW-1:0] FLUSH_LEN = TW'(2 * N - 2);
  localparam logic [TW-1:0] DRAIN_LEN = TW'(N - 1);

  feeder_state_t state, state_nxt;
  logic [KW-1:0] beat_cnt;
  logic [TW-1:0] tmr;
  logic          hs;
  logic          skew_clr;
  logic          tmr_tc;

  assign hs       = in_valid && (state == FEED);
  assign skew_clr = (state != FEED) && (state != FLUSH);
  assign tmr_tc   = (tmr == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = (beat_cnt == '0) ? DRAIN : FEED;
      FEED:    if (hs && (beat_cnt == KW'(1))) state_nxt = FLUSH;
      FLUSH:   if (tmr_tc) state_nxt = DRAIN;
      DRAIN:   if (tmr_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      tmr      <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && start) beat_cnt <= k_len;
      else if (hs)                beat_cnt <= beat_cnt - 1'b1;

      // Phase timer is loaded on entry and counts down to terminal count.
      if (state_nxt == FLUSH && state != FLUSH)      tmr <= FLUSH_LEN;
      else if (state_nxt == DRAIN && state != DRAIN) tmr <= DRAIN_LEN;
      else if (!tmr_tc)                              tmr <= tmr - 1'b1;
    end
  end

  assign in_ready    = (state == FEED);
  assign arr_reset   = (state == CLEAR);
  assign arr_through = (state == DRAIN);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // Lane i sees i skew registers plus the output register; bubbles push zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] a_in, b_in, a_dly, b_dly, left_r, top_r;

    assign a_in = hs ? a_vec[i*W +: W] : '0;
    assign b_in = hs ? b_vec[i*W +: W] : '0;

    skew_line #(.DEPTH(i), .W(W)) u_skew_a (
      .clk   (clk),
      .reset (reset),
      .clear (skew_clr),
      .din   (a_in),
      .dout  (a_dly)
    );

    skew_line #(.DEPTH(i), .W(W)) u_skew_b (
      .clk   (clk),
      .reset (reset),
      .clear (skew_clr),
      .din   (b_in),
      .dout  (b_dly)
    );

    always_ff @(posedge clk) begin
      if (reset || skew_clr) begin
        left_r <= '0;
        top_r  <= '0;
      end else begin
        left_r <= a_dly;
        top_r  <= b_dly;
      end
    end

    assign left_out[i*W +: W] = left_r;
    assign top_out[i*W +: W]  = top_r;
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || state == CLEAR) begin
      stall_cnt <= '0;
    end else if (state == FEED && !in_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a 4x4 PE grid model on its edges.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int KW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, start, in_valid, in_ready;
  logic           arr_reset, arr_through, busy, done;
  logic [KW-1:0]  k_len;
  logic [N*W-1:0] a_vec, b_vec, left_out, top_out;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  systolic_feeder #(.N(N), .W(W), .KW(KW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_len       (k_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_vec       (a_vec),
    .b_vec       (b_vec),
    .left_out    (left_out),
    .top_out     (top_out),
    .arr_reset   (arr_reset),
    .arr_through (arr_through),
    .busy        (busy),
    .done        (done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PE grid: multiply-accumulate normally; in through mode acc shifts down a row.
  logic [7:0] acc  [4][4];
  logic [7:0] rreg [4][4];
  logic [7:0] breg [4][4];
  logic [7:0] lin, tin;

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        lin = (c == 0) ? left_out[r*8 +: 8] : rreg[r][(c == 0) ? 0 : c-1];
        tin = (r == 0) ? top_out[c*8 +: 8]
                       : (arr_through ? acc[(r == 0) ? 0 : r-1][c] : breg[(r == 0) ? 0 : r-1][c]);
        if (reset || arr_reset) begin
          acc[r][c]  <= '0;
          rreg[r][c] <= '0;
          breg[r][c] <= '0;
        end else if (arr_through) begin
          acc[r][c] <= tin;
        end else begin
          acc[r][c]  <= acc[r][c] + lin * tin;
          rreg[r][c] <= lin;
          breg[r][c] <= tin;
        end
      end
    end
  end

  logic        rec_ready [96];
  logic        rec_rst   [96];
  logic        rec_thr   [96];
  logic        rec_done  [96];
  logic [31:0] rec_left  [96];
  logic [31:0] rec_top   [96];
  logic [7:0]  rec_bot   [4][4];
  logic [7:0]  a_tab     [8][4];
  logic [7:0]  b_tab     [8][4];
  logic [7:0]  c_exp     [4][4];
  int          hs_n, done_t, n_ready, n_rst, n_thr, n_done, first_thr;

  function automatic int first_nz(input int lane, input bit use_top);
    for (int t = 0; t < 96; t++) begin
      if (use_top ? (rec_top[t][lane*8 +: 8] != 0) : (rec_left[t][lane*8 +: 8] != 0)) return t;
    end
    return -1;
  endfunction

  task automatic run_job(input int k, input int bubble_at, input int restart_at);
    int feed_idx;
    feed_idx = 0; hs_n = 0; done_t = -1;
    n_ready = 0; n_rst = 0; n_thr = 0; n_done = 0; first_thr = -1;
    for (int t = 0; t < 96; t++) begin
      rec_ready[t] = 0; rec_rst[t] = 0; rec_thr[t] = 0; rec_done[t] = 0;
      rec_left[t] = '0; rec_top[t] = '0;
    end
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); in_valid = 1'b1;
    a_vec = 32'hEEEE_EEEE; b_vec = 32'hDDDD_DDDD;
    for (int t = 1; t < 96 && done_t < 0; t++) begin
      @(negedge clk);
      start = 1'b0; k_len = 8'd9;
      rec_ready[t] = in_ready; rec_rst[t] = arr_reset; rec_thr[t] = arr_through;
      rec_done[t] = done; rec_left[t] = left_out; rec_top[t] = top_out;
      if (in_ready) n_ready++;
      if (arr_reset) n_rst++;
      if (arr_through) begin
        if (first_thr < 0) first_thr = t;
        if (n_thr < 4) for (int c = 0; c < 4; c++) rec_bot[n_thr][c] = acc[3][c];
        n_thr++;
      end
      if (done) begin n_done++; done_t = t; end
      in_valid = 1'b1; a_vec = 32'hEEEE_EEEE; b_vec = 32'hDDDD_DDDD;
      if (in_ready) begin
        if (feed_idx == restart_at) begin start = 1'b1; k_len = 8'd5; end
        if (feed_idx == bubble_at) begin
          in_valid = 1'b0;
        end else begin
          for (int i = 0; i < 4; i++) begin
            a_vec[i*8 +: 8] = a_tab[hs_n & 7][i];
            b_vec[i*8 +: 8] = b_tab[hs_n & 7][i];
          end
          hs_n++;
        end
        feed_idx++;
      end
    end
  endtask

  task automatic load_t1();
    for (int i = 0; i < 4; i++) begin
      a_tab[0][i] = 8'(i + 1);
      b_tab[0][i] = 8'(i + 5);
    end
  endtask

  task automatic check_t1(input string tag);
    check_val({tag, "_done_t"}, done_t, 14);
    check_val({tag, "_rst_t1"}, 32'(rec_rst[1]), 1);
    check_val({tag, "_rst_n"}, n_rst, 1);
    check_val({tag, "_ready_n"}, n_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check_val({tag, "_left_t"}, first_nz(i, 0), 3 + i);
      check_val({tag, "_left_v"}, 32'(rec_left[3+i][i*8 +: 8]), i + 1);
      check_val({tag, "_top_t"}, first_nz(i, 1), 3 + i);
      check_val({tag, "_top_v"}, 32'(rec_top[3+i][i*8 +: 8]), i + 5);
    end
    check_val({tag, "_thr_n"}, n_thr, 4);
    check_val({tag, "_thr_t"}, first_thr, 10);
    check_val({tag, "_done_n"}, n_done, 1);
  endtask

  initial begin
    int seen, n_fl, n_late;

    reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_vec = '0; b_vec = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_ready", 32'(in_ready), 0);
    check_val("rst_ctrl", 32'({arr_reset, arr_through, done}), 0);
    check_val("rst_left", left_out, 0);
    check_val("rst_top", top_out, 0);
    reset = 1'b0;

    // Single beat with in_valid held high throughout.
    load_t1();
    run_job(1, -1, -1);
    check_t1("t1");

    // Three beats with a bubble on the second FEED cycle.
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 4; i++) begin
        a_tab[m][i] = 8'((m + 1) * 16 + i + 1);
        b_tab[m][i] = 8'(8'h80 | ((m + 1) * 16 + i + 1));
      end
    end
    run_job(3, 1, -1);
    check_val("t2_hs", hs_n, 3);
    check_val("t2_ready_n", n_ready, 4);
    check_val("t2_ready_drop", 32'(rec_ready[6]), 0);
    check_val("t2_l0_b0", 32'(rec_left[3][7:0]), 32'h11);
    check_val("t2_l0_bub", 32'(rec_left[4][7:0]), 0);
    check_val("t2_l0_b1", 32'(rec_left[5][7:0]), 32'h21);
    check_val("t2_l0_b2", 32'(rec_left[6][7:0]), 32'h31);
    check_val("t2_l3_bub", 32'(rec_left[7][31:24]), 0);
    check_val("t2_l3_b2", 32'(rec_left[9][31:24]), 32'h34);
    check_val("t2_t2_bub", 32'(rec_top[6][23:16]), 0);
    check_val("t2_t2_b1", 32'(rec_top[7][23:16]), 32'hA3);
    check_val("t2_done_t", done_t, 17);
`ifdef FEEDER_STALL_CNT_EN
    check_val("t2_stall", 32'(stall_cnt), 1);
`endif

    // Empty job goes straight from CLEAR to DRAIN.
    run_job(0, -1, -1);
    check_val("t3_rst_t1", 32'(rec_rst[1]), 1);
    check_val("t3_ready_n", n_ready, 0);
    check_val("t3_thr_n", n_thr, 4);
    check_val("t3_thr_t", first_thr, 2);
    check_val("t3_done_t", done_t, 6);

    // Reset asserted three cycles into FLUSH aborts the job.
    @(negedge clk);
    start = 1'b1; k_len = 8'd2; in_valid = 1'b1;
    a_vec = 32'h0403_0201; b_vec = 32'h0807_0605;
    seen = 0; n_fl = 0;
    for (int t = 0; t < 40 && n_fl < 3; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (in_ready) seen = 1;
      else if (seen != 0) n_fl++;
    end
    check_val("t4_reach_flush", n_fl, 3);
    reset = 1'b1;
    @(negedge clk);
    check_val("t4_busy", 32'(busy), 0);
    check_val("t4_ctrl", 32'({in_ready, arr_reset, arr_through, done}), 0);
    check_val("t4_left", left_out, 0);
    check_val("t4_top", top_out, 0);
    reset = 1'b0;
    n_late = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) n_late++;
    end
    check_val("t4_no_done", n_late, 0);
    load_t1();
    run_job(1, -1, -1);
    check_t1("t4_rerun");

    // start with another k_len during FEED is ignored.
    run_job(2, -1, 0);
    check_val("t5_hs", hs_n, 2);
    check_val("t5_done_t", done_t, 15);

    // Four random beats against the PE grid; bottom edge yields C rows 3..0.
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 4; i++) begin
        a_tab[m][i] = 8'($urandom_range(0, 7));
        b_tab[m][i] = 8'($urandom_range(0, 7));
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        c_exp[i][j] = '0;
        for (int m = 0; m < 4; m++) c_exp[i][j] = c_exp[i][j] + a_tab[m][i] * b_tab[m][j];
      end
    end
    run_job(4, -1, -1);
    check_val("t6_thr_n", n_thr, 4);
    check_val("t6_done_t", done_t, 17);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        check_val($sformatf("t6_c%0d%0d", 3 - d, c), 32'(rec_bot[d][c]), 32'(c_exp[3-d][c]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
